// File: rtl/sram_obi_adapter_pkg.sv
// Shared types and constants for the SRAM OBI adapter.
// resp_t is one bus response; inflight_t is the response kind captured the
// cycle after a grant, while the bank produces its read data.
package sram_obi_adapter_pkg;

    localparam int DataWidth = 32;
    localparam int BeWidth   = 4;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 err;
    } resp_t;

    typedef struct packed {
        logic valid;
        logic is_write;
        logic err;
    } inflight_t;

    // Bank word-address width; a single-word bank still needs one address bit.
    function automatic int calc_addr_width(input int numWords);
        return (numWords <= 1) ? 1 : $clog2(numWords);
    endfunction

endpackage

// File: rtl/sram_obi_adapter_if.sv
// Bundle of the OBI slave-side signals and the SRAM bank signals.
// The slave modport is the adapter's view; the master modport is the view
// of whatever drives the bus and models the bank.
interface sram_obi_adapter_if #(
    parameter int AddrWidth = 13
) ();

    logic                                   bus_req_i;
    logic                                   bus_gnt_o;
    logic [31:0]                            bus_addr_i;
    logic                                   bus_we_i;
    logic [sram_obi_adapter_pkg::BeWidth-1:0]   bus_be_i;
    logic [sram_obi_adapter_pkg::DataWidth-1:0] bus_wdata_i;
    logic                                   bus_rvalid_o;
    logic                                   bus_rready_i;
    logic [sram_obi_adapter_pkg::DataWidth-1:0] bus_rdata_o;
    logic                                   bus_rerr_o;

    logic                                   mem_req_o;
    logic                                   mem_we_o;
    logic [AddrWidth-1:0]                   mem_addr_o;
    logic [sram_obi_adapter_pkg::DataWidth-1:0] mem_wdata_o;
    logic [sram_obi_adapter_pkg::BeWidth-1:0]   mem_be_o;
    logic [sram_obi_adapter_pkg::DataWidth-1:0] mem_rdata_i;

    modport slave (
        input  bus_req_i, bus_addr_i, bus_we_i, bus_be_i, bus_wdata_i, bus_rready_i,
        input  mem_rdata_i,
        output bus_gnt_o, bus_rvalid_o, bus_rdata_o, bus_rerr_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output bus_req_i, bus_addr_i, bus_we_i, bus_be_i, bus_wdata_i, bus_rready_i,
        output mem_rdata_i,
        input  bus_gnt_o, bus_rvalid_o, bus_rdata_o, bus_rerr_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

endinterface

// File: rtl/sram_obi_resp_fifo.sv
// Small response FIFO holding resp_t entries the bus master has not yet
// accepted. Pointers wrap modulo Depth so non-power-of-two depths work.
// A push while full is dropped unless a pop happens in the same cycle.
module sram_obi_resp_fifo
    import sram_obi_adapter_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          i_push,
    input  resp_t                         i_wdata,
    input  logic                          i_pop,
    output resp_t                         o_rdata,
    output logic [$clog2(Depth+1)-1:0]    o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntWidth = $clog2(Depth + 1);

    resp_t                r_mem [Depth];
    logic [PtrWidth-1:0]  r_wrPtr;
    logic [PtrWidth-1:0]  r_rdPtr;
    logic [CntWidth-1:0]  r_count;
    logic                 w_doPush;
    logic                 w_doPop;

    function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full   = (r_count == CntWidth'(Depth));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_obi_adapter.sv
// OBI slave to single SRAM bank bridge with a buffered response path.
// Grants only while the response FIFO plus the in-flight slot has room,
// so read data is never lost when the master stalls rready.
// Optional macro SRAM_OBI_ADAPTER_ERR_EN: out-of-range word addresses are
// granted without touching the bank and answered with rerr=1, rdata=0.
// Without it the upper address bits are ignored and the bank aliases.
module sram_obi_adapter
    import sram_obi_adapter_pkg::*;
#(
    parameter int NumWords  = 8192,
    parameter int RespDepth = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sram_obi_adapter_if.slave  bus
);

    localparam int AddrWidth = calc_addr_width(NumWords);
    localparam int CntWidth  = $clog2(RespDepth + 1);

    inflight_t             r_inflight;
    resp_t                 w_live;
    resp_t                 w_fifoHead;
    resp_t                 w_head;
    logic [CntWidth-1:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_slotFree;
    logic                  w_gnt;
    logic                  w_addrErr;
    logic                  w_unused;

`ifdef SRAM_OBI_ADAPTER_ERR_EN
    assign w_addrErr = ((bus.bus_addr_i >> (AddrWidth + 2)) != 32'd0);
    assign w_unused  = ^bus.bus_addr_i[1:0];
`else
    assign w_addrErr = 1'b0;
    assign w_unused  = ^{bus.bus_addr_i[1:0], bus.bus_addr_i[31:AddrWidth+2], w_head.err};
`endif

    // Room exists only if buffered entries plus the one still in flight leave a slot.
    assign w_slotFree = (32'(w_count) + 32'(r_inflight.valid)) < 32'(RespDepth);
    // Reset is folded in so nothing is granted while the adapter is held in reset.
    assign w_gnt      = bus.bus_req_i & w_slotFree & ~w_full & ~rst_i;

    assign bus.bus_gnt_o   = w_gnt;
    assign bus.mem_req_o   = w_gnt & ~w_addrErr;
    assign bus.mem_we_o    = bus.bus_we_i;
    assign bus.mem_addr_o  = bus.bus_addr_i[AddrWidth+1:2];
    assign bus.mem_wdata_o = bus.bus_wdata_i;
    assign bus.mem_be_o    = bus.bus_be_i;

    // Remember what kind of response the bank will complete next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight <= '0;
        end else begin
            r_inflight.valid    <= w_gnt;
            r_inflight.is_write <= w_gnt & bus.bus_we_i;
            r_inflight.err      <= w_gnt & w_addrErr;
        end
    end

    // Read data is only meaningful for a valid, error-free read; otherwise zero.
    assign w_live = '{
        rdata: (r_inflight.valid & ~r_inflight.is_write & ~r_inflight.err)
               ? bus.mem_rdata_i : '0,
        err:   r_inflight.err
    };

    // Live response bypasses the FIFO when nothing older is waiting and it is taken now.
    assign w_push = r_inflight.valid & ~(w_empty & bus.bus_rready_i);
    assign w_pop  = ~w_empty & bus.bus_rready_i;
    assign w_head = w_empty ? w_live : w_fifoHead;

    sram_obi_resp_fifo #(
        .Depth (RespDepth)
    ) u_respFifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_wdata (w_live),
        .i_pop   (w_pop),
        .o_rdata (w_fifoHead),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.bus_rvalid_o = r_inflight.valid | ~w_empty;
    assign bus.bus_rdata_o  = w_head.rdata;
`ifdef SRAM_OBI_ADAPTER_ERR_EN
    assign bus.bus_rerr_o   = w_head.err;
`else
    assign bus.bus_rerr_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_obi_adapter.sv
// Directed bench for sram_obi_adapter (NumWords=8192, RespDepth=2).
// The bank model returns DEADBEEF for word 4 and C0DE0000|word elsewhere,
// one cycle after a read request, and garbage otherwise.
module tb_sram_obi_adapter;
    import sram_obi_adapter_pkg::*;

    localparam int NumWords  = 8192;
    localparam int RespDepth = 2;
    localparam int AddrWidth = calc_addr_width(NumWords);
`ifdef SRAM_OBI_ADAPTER_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rready;
        logic        expGnt;
        logic        expMemReq;
        logic [31:0] expMemAddr;
        logic        expRvalid;
        logic [31:0] expRdata;
        logic        expRerr;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    sram_obi_adapter_if #(.AddrWidth(AddrWidth)) busIf ();

    sram_obi_adapter #(
        .NumWords  (NumWords),
        .RespDepth (RespDepth)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busIf.slave)
    );

    function automatic logic [31:0] bankModel(input logic [AddrWidth-1:0] word);
        return (word == AddrWidth'(4)) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(word));
    endfunction

    // Bank with one-cycle read latency.
    always @(posedge clk) begin
        busIf.mem_rdata_i <= (busIf.mem_req_o && !busIf.mem_we_o)
                             ? bankModel(busIf.mem_addr_o) : 32'hBAD0BAD0;
    end

    function automatic vector_t mkVec(input logic req, input logic we, input logic [31:0] addr,
                                      input logic [3:0] be, input logic [31:0] wdata,
                                      input logic rready, input logic expGnt, input logic expMemReq,
                                      input logic [31:0] expMemAddr, input logic expRvalid,
                                      input logic [31:0] expRdata, input logic expRerr);
        vector_t v;
        v.req = req; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.rready = rready;
        v.expGnt = expGnt; v.expMemReq = expMemReq; v.expMemAddr = expMemAddr;
        v.expRvalid = expRvalid; v.expRdata = expRdata; v.expRerr = expRerr;
        return v;
    endfunction

    task automatic applyStimulus(input vector_t v);
        @(negedge clk);
        busIf.bus_req_i    = v.req;
        busIf.bus_we_i     = v.we;
        busIf.bus_addr_i   = v.addr;
        busIf.bus_be_i     = v.be;
        busIf.bus_wdata_i  = v.wdata;
        busIf.bus_rready_i = v.rready;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic runVector(input vector_t v, input string tag);
        applyStimulus(v);
        checkOutput({tag, ".gnt"},     32'(busIf.bus_gnt_o),    32'(v.expGnt));
        checkOutput({tag, ".memReq"},  32'(busIf.mem_req_o),    32'(v.expMemReq));
        checkOutput({tag, ".memWe"},   32'(busIf.mem_we_o),     32'(v.we));
        checkOutput({tag, ".memAddr"}, 32'(busIf.mem_addr_o),   v.expMemAddr);
        checkOutput({tag, ".memBe"},   32'(busIf.mem_be_o),     32'(v.be));
        checkOutput({tag, ".memWdata"}, busIf.mem_wdata_o,      v.wdata);
        checkOutput({tag, ".rvalid"},  32'(busIf.bus_rvalid_o), 32'(v.expRvalid));
        checkOutput({tag, ".rdata"},   busIf.bus_rdata_o,       v.expRdata);
        checkOutput({tag, ".rerr"},    32'(busIf.bus_rerr_o),   32'(v.expRerr));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t tbl [13];

        //          req we addr          be    wdata         rdy  gnt memReq  memAddr  rvld rdata                          rerr
        tbl[0]  = mkVec(0, 0, 32'h0,     4'h0, 32'h0,        1,   0,  0,      32'h0,   0,   32'h0,                         0);
        tbl[1]  = mkVec(1, 0, 32'h10,    4'hF, 32'h0,        1,   1,  1,      32'h4,   0,   32'h0,                         0);
        tbl[2]  = mkVec(0, 0, 32'h0,     4'h0, 32'h0,        1,   0,  0,      32'h0,   1,   32'hDEADBEEF,                  0);
        tbl[3]  = mkVec(1, 1, 32'h20,    4'h3, 32'h12345678, 1,   1,  1,      32'h8,   0,   32'h0,                         0);
        tbl[4]  = mkVec(0, 0, 32'h0,     4'h0, 32'h0,        1,   0,  0,      32'h0,   1,   32'h0,                         0);
        tbl[5]  = mkVec(1, 0, 32'h10,    4'hF, 32'h0,        1,   1,  1,      32'h4,   0,   32'h0,                         0);
        tbl[6]  = mkVec(1, 0, 32'h14,    4'hF, 32'h0,        1,   1,  1,      32'h5,   1,   32'hDEADBEEF,                  0);
        tbl[7]  = mkVec(1, 0, 32'h8000,  4'hF, 32'h0,        1,   1,  !ErrEn, 32'h0,   1,   32'hC0DE0005,                  0);
        tbl[8]  = mkVec(0, 0, 32'h0,     4'h0, 32'h0,        1,   0,  0,      32'h0,   1,   ErrEn ? 32'h0 : 32'hC0DE0000,  ErrEn);
        tbl[9]  = mkVec(0, 0, 32'h0,     4'h0, 32'h0,        1,   0,  0,      32'h0,   0,   32'h0,                         0);
        tbl[10] = mkVec(1, 0, 32'h7FFC,  4'hF, 32'h0,        1,   1,  1,      32'h1FFF, 0,  32'h0,                         0);
        tbl[11] = mkVec(0, 0, 32'h0,     4'h0, 32'h0,        1,   0,  0,      32'h0,   1,   32'hC0DE1FFF,                  0);
        tbl[12] = mkVec(0, 0, 32'h0,     4'h0, 32'h0,        1,   0,  0,      32'h0,   0,   32'h0,                         0);

        // Reset state, with a request pending to show nothing is granted.
        busIf.bus_req_i    = 1'b1;
        busIf.bus_we_i     = 1'b0;
        busIf.bus_addr_i   = 32'h0;
        busIf.bus_be_i     = 4'h0;
        busIf.bus_wdata_i  = 32'h0;
        busIf.bus_rready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset.gnt",    32'(busIf.bus_gnt_o),    32'd0);
        checkOutput("reset.memReq", 32'(busIf.mem_req_o),    32'd0);
        checkOutput("reset.rvalid", 32'(busIf.bus_rvalid_o), 32'd0);
        checkOutput("reset.rdata",  busIf.bus_rdata_o,       32'd0);
        checkOutput("reset.rerr",   32'(busIf.bus_rerr_o),   32'd0);
        busIf.bus_req_i = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            runVector(tbl[i], $sformatf("vec%0d", i));
        end

        // Eight back-to-back reads with rready high: grant every cycle, in-order data.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8)
                runVector(mkVec(1, 0, 32'h100 + 32'(4 * i), 4'hF, 32'h0, 1, 1, 1, 32'h40 + 32'(i),
                                i > 0, (i > 0) ? 32'hC0DE0040 + 32'(i - 1) : 32'h0, 0),
                          $sformatf("b2b%0d", i));
            else
                runVector(mkVec(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h0, 1, 32'hC0DE0047, 0),
                          $sformatf("b2b%0d", i));
        end

        // Stall: buffer fills with two responses, grant drops, drain in order, grant resumes.
        runVector(mkVec(1, 0, 32'h140, 4'hF, 32'h0, 1, 1, 1, 32'h50, 0, 32'h0,        0), "stall0");
        runVector(mkVec(1, 0, 32'h144, 4'hF, 32'h0, 0, 1, 1, 32'h51, 1, 32'hC0DE0050, 0), "stall1");
        runVector(mkVec(1, 0, 32'h148, 4'hF, 32'h0, 0, 0, 0, 32'h52, 1, 32'hC0DE0050, 0), "stall2");
        runVector(mkVec(1, 0, 32'h148, 4'hF, 32'h0, 0, 0, 0, 32'h52, 1, 32'hC0DE0050, 0), "stall3");
        runVector(mkVec(1, 0, 32'h148, 4'hF, 32'h0, 1, 0, 0, 32'h52, 1, 32'hC0DE0050, 0), "stall4");
        runVector(mkVec(1, 0, 32'h148, 4'hF, 32'h0, 1, 1, 1, 32'h52, 1, 32'hC0DE0051, 0), "stall5");
        runVector(mkVec(0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 0, 32'h0,  1, 32'hC0DE0052, 0), "stall6");
        runVector(mkVec(0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 0, 32'h0,  0, 32'h0,        0), "stall7");

        // Reset with two buffered responses; everything is discarded.
        runVector(mkVec(1, 0, 32'h180, 4'hF, 32'h0, 0, 1, 1, 32'h60, 0, 32'h0,        0), "rst0");
        runVector(mkVec(1, 0, 32'h184, 4'hF, 32'h0, 0, 1, 1, 32'h61, 1, 32'hC0DE0060, 0), "rst1");
        runVector(mkVec(0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 0, 32'h0,  1, 32'hC0DE0060, 0), "rst2");
        runVector(mkVec(0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 0, 32'h0,  1, 32'hC0DE0060, 0), "rst3");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstMid.rvalid", 32'(busIf.bus_rvalid_o), 32'd0);
        checkOutput("rstMid.rdata",  busIf.bus_rdata_o,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstPost.rvalid", 32'(busIf.bus_rvalid_o), 32'd0);
        // Two grants with rready low prove the buffer really came back empty.
        runVector(mkVec(1, 0, 32'h188, 4'hF, 32'h0, 0, 1, 1, 32'h62, 0, 32'h0,        0), "post0");
        runVector(mkVec(1, 0, 32'h18C, 4'hF, 32'h0, 0, 1, 1, 32'h63, 1, 32'hC0DE0062, 0), "post1");
        runVector(mkVec(0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 0, 32'h0,  1, 32'hC0DE0062, 0), "post2");
        runVector(mkVec(0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 0, 32'h0,  1, 32'hC0DE0063, 0), "post3");
        runVector(mkVec(0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 0, 32'h0,  0, 32'h0,        0), "post4");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
